// File: rtl/vc_fifo_bank_pkg.sv
// Shared types and helpers for the virtual-channel FIFO bank.
// Holds the per-channel operation decode, so every channel resolves read/write collisions the same way.
package vc_fifo_bank_pkg;

    localparam int DEF_BW     = 6;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NUM_VC = 2;

    typedef struct packed {
        logic wr_ok;
        logic rd_ok;
        logic err;
    } ch_op_t;

    // A write to a full channel still proceeds when a read frees the head slot in the same cycle.
    // A read of an empty channel is an underflow, even when a write lands in that cycle (there is no bypass).
    function automatic ch_op_t decode_op(input logic wr, input logic rd,
                                         input logic full, input logic empty);
        ch_op_t op;
        op.wr_ok = wr & (~full | rd);
        op.rd_ok = rd & ~empty;
        op.err   = (wr & full & ~rd) | (rd & empty);
        return op;
    endfunction

    function automatic int vc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_fifo_bank_ch.sv
// One virtual-channel FIFO: storage, pointers, count, threshold flags, sticky error and registered read port.
module vc_fifo_bank_ch
    import vc_fifo_bank_pkg::*;
#(
    parameter int BW    = DEF_BW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             wr,
    input  logic [BW-1:0]    wdata,
    input  logic             rd,
    input  logic [CNT_W-1:0] bajo,
    input  logic [CNT_W-1:0] alto,
    input  logic             err_clr,
    output logic [BW-1:0]    data_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             error_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [BW-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [BW-1:0]    dout_r;
    logic             vout_r;
    logic             err_r;
    logic             full_s;
    logic             empty_s;
    ch_op_t           op_s;

    assign full_s  = (cnt_r == CNT_W'(DEPTH));
    assign empty_s = (cnt_r == {CNT_W{1'b0}});

    // Resolve this cycle's read/write request against the current fill level.
    always_comb begin
        op_s = decode_op(wr, rd, full_s, empty_s);
    end

    // Storage array; its contents become meaningless after reset because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (op_s.wr_ok) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers, count, read register and sticky error (a set in the same cycle as a clear wins).
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wptr_r <= {PTR_W{1'b0}};
            rptr_r <= {PTR_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            dout_r <= {BW{1'b0}};
            vout_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(op_s.wr_ok) - CNT_W'(op_s.rd_ok);
            vout_r <= op_s.rd_ok;
            if (op_s.wr_ok) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (op_s.rd_ok) begin
                dout_r <= mem_r[rptr_r];
                rptr_r <= rptr_r + PTR_W'(1);
            end
            if (op_s.err) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end
        end
    end

    assign data_out     = dout_r;
    assign valid_out    = vout_r;
    assign occupancy    = cnt_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (cnt_r >= alto);
    assign almost_empty = (cnt_r <= bajo);
    assign error_out    = err_r;

endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent FIFOs sharing one write port steered by vc_sel_in.
// Each channel has its own read strobe, flags, thresholds and sticky error.
module vc_fifo_bank
    import vc_fifo_bank_pkg::*;
#(
    parameter int BW     = DEF_BW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_VC = DEF_NUM_VC,
    parameter int VC_W   = vc_width(NUM_VC),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    valid_in,
    input  logic [VC_W-1:0]         vc_sel_in,
    input  logic [BW-1:0]           data_in,
    input  logic [NUM_VC-1:0]       vc_rd,
    input  logic [NUM_VC*CNT_W-1:0] umbral_bajo,
    input  logic [NUM_VC*CNT_W-1:0] umbral_alto,
    input  logic [NUM_VC-1:0]       err_clr,
    output logic [NUM_VC*BW-1:0]    data_out,
    output logic [NUM_VC-1:0]       valid_out,
    output logic [NUM_VC*CNT_W-1:0] occupancy,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC-1:0]       almost_empty,
    output logic [NUM_VC-1:0]       error_out
);

    logic [NUM_VC-1:0] wr_vec_s;

    // One-hot write steering; a selector beyond the last channel matches nothing and is silently dropped.
    always_comb begin
        wr_vec_s = {NUM_VC{1'b0}};
        for (int i = 0; i < NUM_VC; i++) begin
            wr_vec_s[i] = valid_in && (int'(vc_sel_in) == i);
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_ch
        vc_fifo_bank_ch #(
            .BW    (BW),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk          (clk),
            .reset_L      (reset_L),
            .wr           (wr_vec_s[g]),
            .wdata        (data_in),
            .rd           (vc_rd[g]),
            .bajo         (umbral_bajo[g*CNT_W +: CNT_W]),
            .alto         (umbral_alto[g*CNT_W +: CNT_W]),
            .err_clr      (err_clr[g]),
            .data_out     (data_out[g*BW +: BW]),
            .valid_out    (valid_out[g]),
            .occupancy    (occupancy[g*CNT_W +: CNT_W]),
            .full         (full[g]),
            .empty        (empty[g]),
            .almost_full  (almost_full[g]),
            .almost_empty (almost_empty[g]),
            .error_out    (error_out[g])
        );
    end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed plus randomized bench for vc_fifo_bank against a queue-based reference model.
module tb_vc_fifo_bank;

    localparam int BW     = 6;
    localparam int DEPTH  = 16;
    localparam int NUM_VC = 2;
    localparam int VC_W   = 1;
    localparam int CNT_W  = 5;

    logic                    clk = 1'b0;
    logic                    reset_L = 1'b1;
    logic                    valid_in = 1'b0;
    logic [VC_W-1:0]         vc_sel_in = '0;
    logic [BW-1:0]           data_in = '0;
    logic [NUM_VC-1:0]       vc_rd = '0;
    logic [NUM_VC*CNT_W-1:0] umbral_bajo;
    logic [NUM_VC*CNT_W-1:0] umbral_alto;
    logic [NUM_VC-1:0]       err_clr = '0;
    logic [NUM_VC*BW-1:0]    data_out;
    logic [NUM_VC-1:0]       valid_out;
    logic [NUM_VC*CNT_W-1:0] occupancy;
    logic [NUM_VC-1:0]       full, empty, almost_full, almost_empty, error_out;

    vc_fifo_bank #(.BW(BW), .DEPTH(DEPTH), .NUM_VC(NUM_VC), .VC_W(VC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .vc_sel_in(vc_sel_in),
        .data_in(data_in), .vc_rd(vc_rd), .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
        .err_clr(err_clr), .data_out(data_out), .valid_out(valid_out), .occupancy(occupancy),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .error_out(error_out)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per channel plus expected registered outputs.
    logic [BW-1:0] mq [NUM_VC][$];
    logic [BW-1:0] m_dout [NUM_VC];
    logic          m_vout [NUM_VC];
    logic          m_err  [NUM_VC];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, ch, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_VC; c++) begin
            mq[c].delete();
            m_dout[c] = '0;
            m_vout[c] = 1'b0;
            m_err[c]  = 1'b0;
        end
    endtask

    // Applies one clock edge worth of the channel rules to the model.
    task automatic model_step();
        for (int c = 0; c < NUM_VC; c++) begin
            int  sz;
            bit  wr, rd, ovf, unf;
            sz  = mq[c].size();
            wr  = valid_in && (int'(vc_sel_in) == c);
            rd  = vc_rd[c];
            unf = rd && (sz == 0);
            ovf = wr && !rd && (sz == DEPTH);
            m_vout[c] = rd && (sz > 0);
            if (m_vout[c]) m_dout[c] = mq[c].pop_front();
            if (wr && !ovf) mq[c].push_back(data_in);
            if (ovf || unf) m_err[c] = 1'b1;
            else if (err_clr[c]) m_err[c] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NUM_VC; c++) begin
            int occ, lo, hi;
            occ = mq[c].size();
            lo  = int'(umbral_bajo[c*CNT_W +: CNT_W]);
            hi  = int'(umbral_alto[c*CNT_W +: CNT_W]);
            chk("data_out", c, 32'(data_out[c*BW +: BW]), 32'(m_dout[c]));
            chk("valid_out", c, 32'(valid_out[c]), 32'(m_vout[c]));
            chk("error_out", c, 32'(error_out[c]), 32'(m_err[c]));
            chk("occupancy", c, 32'(occupancy[c*CNT_W +: CNT_W]), 32'(occ));
            chk("full", c, 32'(full[c]), 32'(occ == DEPTH));
            chk("empty", c, 32'(empty[c]), 32'(occ == 0));
            chk("almost_full", c, 32'(almost_full[c]), 32'(occ >= hi));
            chk("almost_empty", c, 32'(almost_empty[c]), 32'(occ <= lo));
        end
    endtask

    task automatic cyc(input logic v, input logic [VC_W-1:0] s, input logic [BW-1:0] d,
                       input logic [NUM_VC-1:0] r, input logic [NUM_VC-1:0] cl);
        valid_in  = v;
        vc_sel_in = s;
        data_in   = d;
        vc_rd     = r;
        err_clr   = cl;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_thr(input int lo, input int hi);
        for (int c = 0; c < NUM_VC; c++) begin
            umbral_bajo[c*CNT_W +: CNT_W] = CNT_W'(lo);
            umbral_alto[c*CNT_W +: CNT_W] = CNT_W'(hi);
        end
    endtask

    initial begin
        set_thr(2, 14);
        model_reset();
        #2 reset_L = 1'b0;
        #1 check_all();
        @(negedge clk);
        reset_L = 1'b1;

        // Three words through channel 1, channel 0 stays idle.
        cyc(1'b1, 1'b1, 6'h0A, 2'b00, 2'b00);
        cyc(1'b1, 1'b1, 6'h0B, 2'b00, 2'b00);
        cyc(1'b1, 1'b1, 6'h0C, 2'b00, 2'b00);
        chk("t1_occ3", 1, 32'(occupancy[CNT_W +: CNT_W]), 32'd3);
        cyc(1'b0, 1'b0, 6'h00, 2'b10, 2'b00);
        chk("t1_first", 1, 32'(data_out[BW +: BW]), 32'h0A);
        cyc(1'b0, 1'b0, 6'h00, 2'b10, 2'b00);
        cyc(1'b0, 1'b0, 6'h00, 2'b10, 2'b00);
        chk("t1_last", 1, 32'(data_out[BW +: BW]), 32'h0C);
        cyc(1'b0, 1'b0, 6'h00, 2'b00, 2'b00);

        // Fill channel 0, overflow, clear, then read back in order.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, BW'(i + 16), 2'b00, 2'b00);
        chk("t2_full", 0, 32'(full[0]), 32'd1);
        cyc(1'b1, 1'b0, 6'h3F, 2'b00, 2'b00);
        chk("t2_ovf_err", 0, 32'(error_out[0]), 32'd1);
        cyc(1'b0, 1'b0, 6'h00, 2'b00, 2'b01);
        chk("t2_clr", 0, 32'(error_out[0]), 32'd0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 6'h00, 2'b01, 2'b00);

        // Underflow alone, then write+read on an empty channel.
        cyc(1'b0, 1'b0, 6'h00, 2'b01, 2'b00);
        cyc(1'b0, 1'b0, 6'h00, 2'b00, 2'b01);
        cyc(1'b1, 1'b0, 6'h15, 2'b01, 2'b00);
        chk("t3_occ1", 0, 32'(occupancy[0 +: CNT_W]), 32'd1);
        chk("t3_err", 0, 32'(error_out[0]), 32'd1);
        cyc(1'b0, 1'b0, 6'h00, 2'b01, 2'b01);

        // Simultaneous write and read on a full channel, then drain past the wrap.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, BW'(i + 1), 2'b00, 2'b00);
        cyc(1'b1, 1'b0, 6'h2A, 2'b01, 2'b00);
        chk("t4_occ16", 0, 32'(occupancy[0 +: CNT_W]), 32'd16);
        chk("t4_noerr", 0, 32'(error_out[0]), 32'd0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 6'h00, 2'b01, 2'b00);
        chk("t4_last_x", 0, 32'(data_out[0 +: BW]), 32'h2A);

        // Threshold flags during fill, with a live change of the almost-full level.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 1'b0, BW'(i), 2'b00, 2'b00);
            if (i == 2) chk("t5_ae_at3", 0, 32'(almost_empty[0]), 32'd0);
            if (i == 12) begin
                set_thr(2, 10);
                #1 chk("t5_af_live", 0, 32'(almost_full[0]), 32'd1);
                check_all();
            end
        end
        set_thr(2, 14);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 6'h00, 2'b01, 2'b00);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, BW'(i + 40), 2'b00, 2'b00);
        cyc(1'b0, 1'b0, 6'h00, 2'b01, 2'b00);
        reset_L = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        reset_L = 1'b1;
        cyc(1'b0, 1'b0, 6'h00, 2'b11, 2'b00);
        chk("t6_unf", 0, 32'(error_out), 32'd3);

        // Randomized traffic with occasional threshold and clear activity.
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) set_thr($urandom_range(0, 16), $urandom_range(0, 16));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), BW'($urandom),
                NUM_VC'($urandom_range(0, 3) & $urandom_range(0, 3)),
                NUM_VC'(($urandom_range(0, 7) == 0) ? 3 : 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
